// File: rtl/gpr_wb_scheduler.sv
// GPR writeback scheduler: round-robin arbitration of ALU/LSU writebacks onto the
// single GPR write port, with a per-register busy scoreboard gating issue.
module gpr_wb_scheduler #(
    parameter int GPR_ADDR_WIDTH  = 5,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    localparam int NUM_REGS  = 2 ** GPR_ADDR_WIDTH,
    localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    // Issue side: iss_ready is a pure function of the presented operands and
    // scoreboard state; an issue fires on iss_valid & iss_ready.
    input  logic                      iss_valid,
    output logic                      iss_ready,
    input  logic [1:0]                iss_ren,
    input  logic [GPR_ADDR_WIDTH-1:0] iss_rs1,
    input  logic [GPR_ADDR_WIDTH-1:0] iss_rs2,
    input  logic                      iss_wen,
    input  logic [GPR_ADDR_WIDTH-1:0] iss_rd,
    // Writeback side: a requester holds valid/rd/data stable until it sees its
    // ready high; ready is asserted only in the cycle the request is granted.
    input  logic                      alu_wb_valid,
    output logic                      alu_wb_ready,
    input  logic [GPR_ADDR_WIDTH-1:0] alu_wb_rd,
    input  logic [DATA_WIDTH-1:0]     alu_wb_data,
    input  logic                      lsu_wb_valid,
    output logic                      lsu_wb_ready,
    input  logic [GPR_ADDR_WIDTH-1:0] lsu_wb_rd,
    input  logic [DATA_WIDTH-1:0]     lsu_wb_data,
    output logic                      gpr_wen,
    output logic [GPR_ADDR_WIDTH-1:0] gpr_waddr,
    output logic [DATA_WIDTH-1:0]     gpr_wdata,
    output logic [CNT_WIDTH-1:0]      outstanding,
    output logic                      wb_err
);

    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [NUM_REGS-1:0]       busy_q, busy_d;
    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
    logic                      last_alu_q, last_alu_d;
    logic                      gpr_wen_q, gpr_wen_d;
    logic [GPR_ADDR_WIDTH-1:0] gpr_waddr_q, gpr_waddr_d;
    logic [DATA_WIDTH-1:0]     gpr_wdata_q, gpr_wdata_d;
    logic                      clr_q, clr_d;
    logic                      err_q, err_d;

    logic                      sel_alu, sel_lsu, grant;
    logic [GPR_ADDR_WIDTH-1:0] wb_rd;
    logic [DATA_WIDTH-1:0]     wb_data;
    logic                      wb_rd_nz, wb_busy;
    logic                      iss_set;

    assign iss_ready = !(iss_ren[0] & busy_q[iss_rs1])
                     & !(iss_ren[1] & busy_q[iss_rs2])
                     & !(iss_wen & (iss_rd != '0) & busy_q[iss_rd])
                     & (cnt_q < MAX_CNT);

    assign iss_set = iss_valid & iss_ready & iss_wen & (iss_rd != '0);

    // On a tie the requester that was not granted last wins.
    assign sel_lsu = lsu_wb_valid & (~alu_wb_valid | last_alu_q);
    assign sel_alu = alu_wb_valid & ~sel_lsu;
    assign grant   = sel_alu | sel_lsu;
    assign wb_rd   = sel_lsu ? lsu_wb_rd : alu_wb_rd;
    assign wb_data = sel_lsu ? lsu_wb_data : alu_wb_data;
    assign wb_rd_nz = (wb_rd != '0);
    assign wb_busy  = busy_q[wb_rd];

    assign alu_wb_ready = sel_alu;
    assign lsu_wb_ready = sel_lsu;

    always_comb begin
        last_alu_d  = last_alu_q;
        gpr_wen_d   = grant & wb_rd_nz;
        gpr_waddr_d = gpr_waddr_q;
        gpr_wdata_d = gpr_wdata_q;
        // A write to a register that is not busy must not release anyone
        // else's scoreboard entry, so the clear intent is registered separately.
        clr_d       = grant & wb_rd_nz & wb_busy;
        err_d       = err_q | (grant & wb_rd_nz & ~wb_busy);
        if (sel_alu) begin
            last_alu_d = 1'b1;
        end else if (sel_lsu) begin
            last_alu_d = 1'b0;
        end
        if (grant) begin
            gpr_waddr_d = wb_rd;
            gpr_wdata_d = wb_data;
        end
    end

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        if (clr_q) begin
            busy_d[gpr_waddr_q] = 1'b0;
        end
        if (iss_set) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
        case ({iss_set, clr_q})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q      <= '0;
            cnt_q       <= '0;
            last_alu_q  <= 1'b1;
            gpr_wen_q   <= 1'b0;
            gpr_waddr_q <= '0;
            gpr_wdata_q <= '0;
            clr_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
            last_alu_q  <= last_alu_d;
            gpr_wen_q   <= gpr_wen_d;
            gpr_waddr_q <= gpr_waddr_d;
            gpr_wdata_q <= gpr_wdata_d;
            clr_q       <= clr_d;
            err_q       <= err_d;
        end
    end

    assign gpr_wen     = gpr_wen_q;
    assign gpr_waddr   = gpr_waddr_q;
    assign gpr_wdata   = gpr_wdata_q;
    assign outstanding = cnt_q;
    assign wb_err      = err_q;

endmodule

// File: tb/tb_gpr_wb_scheduler.sv
// Directed bench for gpr_wb_scheduler: per-cycle vector table plus hand-written
// sequences for the outstanding limit, protocol error and mid-operation reset.
module tb_gpr_wb_scheduler;

    logic        clk;
    logic        rst;
    logic        iss_valid;
    logic        iss_ready;
    logic [1:0]  iss_ren;
    logic [4:0]  iss_rs1, iss_rs2, iss_rd;
    logic        iss_wen;
    logic        alu_wb_valid, alu_wb_ready;
    logic [4:0]  alu_wb_rd;
    logic [31:0] alu_wb_data;
    logic        lsu_wb_valid, lsu_wb_ready;
    logic [4:0]  lsu_wb_rd;
    logic [31:0] lsu_wb_data;
    logic        gpr_wen;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic [2:0]  outstanding;
    logic        wb_err;

    int total;
    int bad;

    gpr_wb_scheduler #(
        .GPR_ADDR_WIDTH (5),
        .DATA_WIDTH     (32),
        .MAX_OUTSTANDING(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .iss_valid    (iss_valid),
        .iss_ready    (iss_ready),
        .iss_ren      (iss_ren),
        .iss_rs1      (iss_rs1),
        .iss_rs2      (iss_rs2),
        .iss_wen      (iss_wen),
        .iss_rd       (iss_rd),
        .alu_wb_valid (alu_wb_valid),
        .alu_wb_ready (alu_wb_ready),
        .alu_wb_rd    (alu_wb_rd),
        .alu_wb_data  (alu_wb_data),
        .lsu_wb_valid (lsu_wb_valid),
        .lsu_wb_ready (lsu_wb_ready),
        .lsu_wb_rd    (lsu_wb_rd),
        .lsu_wb_data  (lsu_wb_data),
        .gpr_wen      (gpr_wen),
        .gpr_waddr    (gpr_waddr),
        .gpr_wdata    (gpr_wdata),
        .outstanding  (outstanding),
        .wb_err       (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [1:0]  ren;
        logic [4:0]  rs1, rs2;
        logic        wen;
        logic [4:0]  rd;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldat;
        logic        e_ir, e_ar, e_lr, e_wen;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic [2:0]  e_out;
        logic        e_err;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs[NVEC];

    function automatic vec_t v(
        input logic iv, input logic [1:0] ren, input logic [4:0] rs1, input logic [4:0] rs2,
        input logic wen, input logic [4:0] rd,
        input logic av, input logic [4:0] ard, input logic [31:0] adat,
        input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
        input logic e_ir, input logic e_ar, input logic e_lr, input logic e_wen,
        input logic [4:0] e_wa, input logic [31:0] e_wd, input logic [2:0] e_out, input logic e_err);
        vec_t r;
        r.iv = iv; r.ren = ren; r.rs1 = rs1; r.rs2 = rs2; r.wen = wen; r.rd = rd;
        r.av = av; r.ard = ard; r.adat = adat;
        r.lv = lv; r.lrd = lrd; r.ldat = ldat;
        r.e_ir = e_ir; r.e_ar = e_ar; r.e_lr = e_lr; r.e_wen = e_wen;
        r.e_wa = e_wa; r.e_wd = e_wd; r.e_out = e_out; r.e_err = e_err;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        iss_valid = 1'b0; iss_ren = 2'b00; iss_rs1 = '0; iss_rs2 = '0;
        iss_wen = 1'b0; iss_rd = '0;
        alu_wb_valid = 1'b0; alu_wb_rd = '0; alu_wb_data = '0;
        lsu_wb_valid = 1'b0; lsu_wb_rd = '0; lsu_wb_data = '0;
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd);
        iss_valid = 1'b1; iss_ren = 2'b00; iss_wen = 1'b1; iss_rd = rd;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle_inputs();
        rst = 1'b1;

        // Scenario 1: RAW stall and latency-1 writeback of rd=5.
        vecs[0]  = v(1, 2'b11, 1, 2, 1, 5,  0, 0, 0,  0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = v(1, 2'b01, 5, 0, 0, 0,  1, 5, 32'hDEADBEEF,  0, 0, 0,  0, 1, 0, 0, 0, 0, 1, 0);
        vecs[2]  = v(1, 2'b01, 5, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 1, 5, 32'hDEADBEEF, 1, 0);
        vecs[3]  = v(1, 2'b01, 5, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 0, 0, 0, 5, 32'hDEADBEEF, 0, 0);
        // Scenario 2: tie between ALU rd=3 and LSU rd=4, LSU first.
        vecs[4]  = v(1, 2'b00, 0, 0, 1, 3,  0, 0, 0,  0, 0, 0,  1, 0, 0, 0, 5, 32'hDEADBEEF, 0, 0);
        vecs[5]  = v(1, 2'b00, 0, 0, 1, 4,  0, 0, 0,  0, 0, 0,  1, 0, 0, 0, 5, 32'hDEADBEEF, 1, 0);
        vecs[6]  = v(0, 2'b00, 0, 0, 0, 0,  1, 3, 32'h33,  1, 4, 32'h44,  1, 0, 1, 0, 5, 32'hDEADBEEF, 2, 0);
        vecs[7]  = v(0, 2'b00, 0, 0, 0, 0,  1, 3, 32'h33,  0, 0, 0,  1, 1, 0, 1, 4, 32'h44, 2, 0);
        vecs[8]  = v(0, 2'b00, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 0, 0, 1, 3, 32'h33, 1, 0);
        vecs[9]  = v(0, 2'b00, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 0, 0, 0, 3, 32'h33, 0, 0);
        // Scenario 3: fill to the limit, then both requesters valid for 6 cycles.
        vecs[10] = v(1, 2'b00, 0, 0, 1, 8,  0, 0, 0,  0, 0, 0,  1, 0, 0, 0, 3, 32'h33, 0, 0);
        vecs[11] = v(1, 2'b00, 0, 0, 1, 9,  0, 0, 0,  0, 0, 0,  1, 0, 0, 0, 3, 32'h33, 1, 0);
        vecs[12] = v(1, 2'b00, 0, 0, 1, 10, 0, 0, 0,  0, 0, 0,  1, 0, 0, 0, 3, 32'h33, 2, 0);
        vecs[13] = v(1, 2'b00, 0, 0, 1, 11, 0, 0, 0,  0, 0, 0,  1, 0, 0, 0, 3, 32'h33, 3, 0);
        vecs[14] = v(0, 2'b00, 0, 0, 0, 0,  1, 9, 32'h109,  1, 8, 32'h108,  0, 0, 1, 0, 3, 32'h33, 4, 0);
        vecs[15] = v(0, 2'b00, 0, 0, 0, 0,  1, 9, 32'h109,  1, 10, 32'h10A, 0, 1, 0, 1, 8, 32'h108, 4, 0);
        vecs[16] = v(1, 2'b00, 0, 0, 1, 12, 1, 11, 32'h10B, 1, 10, 32'h10A, 1, 0, 1, 1, 9, 32'h109, 3, 0);
        vecs[17] = v(1, 2'b00, 0, 0, 1, 13, 1, 11, 32'h10B, 1, 12, 32'h10C, 1, 1, 0, 1, 10, 32'h10A, 3, 0);
        vecs[18] = v(0, 2'b00, 0, 0, 0, 0,  1, 13, 32'h10D, 1, 12, 32'h10C, 1, 0, 1, 1, 11, 32'h10B, 3, 0);
        vecs[19] = v(0, 2'b00, 0, 0, 0, 0,  1, 13, 32'h10D, 1, 0, 32'h0,    1, 1, 0, 1, 12, 32'h10C, 2, 0);
        vecs[20] = v(0, 2'b00, 0, 0, 0, 0,  0, 0, 0,        1, 0, 32'h0,    1, 0, 1, 1, 13, 32'h10D, 1, 0);
        vecs[21] = v(0, 2'b00, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gpr_wen", gpr_wen, 0);
        chk("rst_waddr", gpr_waddr, 0);
        chk("rst_wdata", gpr_wdata, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_wb_err", wb_err, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            next_cycle();
            iss_valid = vecs[i].iv;  iss_ren = vecs[i].ren;
            iss_rs1 = vecs[i].rs1;   iss_rs2 = vecs[i].rs2;
            iss_wen = vecs[i].wen;   iss_rd = vecs[i].rd;
            alu_wb_valid = vecs[i].av; alu_wb_rd = vecs[i].ard; alu_wb_data = vecs[i].adat;
            lsu_wb_valid = vecs[i].lv; lsu_wb_rd = vecs[i].lrd; lsu_wb_data = vecs[i].ldat;
            #3;
            chk($sformatf("v%0d_iss_ready", i), iss_ready, vecs[i].e_ir);
            chk($sformatf("v%0d_alu_ready", i), alu_wb_ready, vecs[i].e_ar);
            chk($sformatf("v%0d_lsu_ready", i), lsu_wb_ready, vecs[i].e_lr);
            chk($sformatf("v%0d_gpr_wen", i), gpr_wen, vecs[i].e_wen);
            chk($sformatf("v%0d_waddr", i), gpr_waddr, vecs[i].e_wa);
            chk($sformatf("v%0d_wdata", i), gpr_wdata, vecs[i].e_wd);
            chk($sformatf("v%0d_outstanding", i), outstanding, vecs[i].e_out);
            chk($sformatf("v%0d_wb_err", i), wb_err, vecs[i].e_err);
        end

        // Outstanding limit: four writers issued, fifth blocked even without a write.
        for (int r = 1; r <= 4; r++) begin
            next_cycle();
            idle_inputs();
            issue(5'(r));
        end
        next_cycle();
        idle_inputs();
        issue(5'd6);
        #3;
        chk("lim_outstanding", outstanding, 4);
        chk("lim_iss_ready_wr", iss_ready, 0);
        iss_wen = 1'b0;
        #1;
        chk("lim_iss_ready_nowr", iss_ready, 0);
        iss_wen = 1'b1;
        next_cycle();
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd2; alu_wb_data = 32'h222;
        #3;
        chk("lim_alu_grant", alu_wb_ready, 1);
        chk("lim_iss_ready_n", iss_ready, 0);
        next_cycle();
        alu_wb_valid = 1'b0;
        #3;
        chk("lim_iss_ready_n1", iss_ready, 0);
        chk("lim_wen_n1", gpr_wen, 1);
        chk("lim_waddr_n1", gpr_waddr, 2);
        next_cycle();
        #3;
        chk("lim_iss_ready_n2", iss_ready, 1);
        chk("lim_outstanding_n2", outstanding, 3);
        next_cycle();
        idle_inputs();
        #3;
        chk("lim_outstanding_refill", outstanding, 4);

        // rd=0 writeback is accepted without a write; non-busy rd=7 flags an error.
        next_cycle();
        lsu_wb_valid = 1'b1; lsu_wb_rd = 5'd0; lsu_wb_data = 32'h55;
        #3;
        chk("rd0_lsu_ready", lsu_wb_ready, 1);
        next_cycle();
        idle_inputs();
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd7; alu_wb_data = 32'h77;
        #3;
        chk("rd0_gpr_wen", gpr_wen, 0);
        chk("err_alu_ready", alu_wb_ready, 1);
        chk("err_before", wb_err, 0);
        next_cycle();
        idle_inputs();
        #3;
        chk("err_set", wb_err, 1);
        chk("err_gpr_wen", gpr_wen, 1);
        chk("err_waddr", gpr_waddr, 7);
        chk("err_wdata", gpr_wdata, 32'h77);
        chk("err_outstanding", outstanding, 4);
        next_cycle();
        #3;
        chk("err_sticky", wb_err, 1);
        chk("err_outstanding_after", outstanding, 4);
        chk("err_wen_drop", gpr_wen, 0);

        // Free one slot, issue rd=5, grant its writeback, then reset mid-write.
        next_cycle();
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd1; alu_wb_data = 32'h11;
        #3;
        chk("rs_alu_grant1", alu_wb_ready, 1);
        next_cycle();
        idle_inputs();
        next_cycle();
        issue(5'd5);
        #3;
        chk("rs_outstanding3", outstanding, 3);
        chk("rs_issue5_ready", iss_ready, 1);
        next_cycle();
        idle_inputs();
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd5; alu_wb_data = 32'hAB;
        #3;
        chk("rs_alu_grant5", alu_wb_ready, 1);
        chk("rs_outstanding4", outstanding, 4);
        next_cycle();
        idle_inputs();
        chk("rs_wen_pre", gpr_wen, 1);
        chk("rs_waddr_pre", gpr_waddr, 5);
        #1;
        rst = 1'b1;
        #1;
        chk("rs_wen_async", gpr_wen, 0);
        chk("rs_waddr_async", gpr_waddr, 0);
        chk("rs_wdata_async", gpr_wdata, 0);
        chk("rs_outstanding_async", outstanding, 0);
        chk("rs_err_async", wb_err, 0);
        next_cycle();
        chk("rs_wen_hold", gpr_wen, 0);
        @(negedge clk);
        rst = 1'b0;
        iss_ren = 2'b11; iss_rs1 = 5'd5; iss_rs2 = 5'd6;
        #1;
        chk("rs_iss_ready_after", iss_ready, 1);
        next_cycle();
        chk("rs_wen_after", gpr_wen, 0);
        chk("rs_outstanding_after", outstanding, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
